// File: rtl/lock_pkg.sv
// Shared types and board timing defaults for the lock's pushbutton front ends.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } btn_state_t;

    // 100 MHz board clock: 10 ms debounce, 2 s long press.
    localparam int unsigned DEB_10MS = 1000000;
    localparam int unsigned LONG_2S  = 200000000;

endpackage

// File: rtl/button_conditioner_sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit, cleared to 0 on reset.
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronise, debounce press/release independently, and emit
// registered level plus one-cycle press, release and long-press strobes.
module button_conditioner
    import lock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
    parameter int unsigned LONG_CYCLES     = LONG_2S
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Button,
    output logic Level,
    output logic Pulse,
    output logic ReleasePulse,
    output logic LongPulse
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic btn_s;

    btn_state_t        state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_q, long_d;
    logic              level_q, level_d;
    logic              pulse_q, pulse_d;
    logic              rel_q, rel_d;
    logic              longp_q, longp_d;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(Clock),
        .rst_i(Reset),
        .d_i  (Button),
        .q_o  (btn_s)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            rel_q      <= 1'b0;
            longp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            rel_q      <= rel_d;
            longp_q    <= longp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = long_q;
        pulse_d    = 1'b0;
        rel_d      = 1'b0;
        longp_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = DEB_ONE;
                end else begin
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = PRESSED;
                    hold_cnt_d = HOLD_ONE;
                    long_d     = 1'b0;
                    pulse_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    long_d    = 1'b0;
                    deb_cnt_d = DEB_ONE;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = LONG_HELD;
                    longp_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    long_d    = 1'b1;
                    deb_cnt_d = DEB_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A release glitch resumes the held state with hold_cnt intact and no re-strobe.
                if (btn_s) begin
                    state_d   = long_q ? LONG_HELD : PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    rel_d     = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == RELEASE_WAIT);
    end

    assign Level        = level_q;
    assign Pulse        = pulse_q;
    assign ReleasePulse = rel_q;
    assign LongPulse    = longp_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/long-press timing.
module tb_button_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;

    logic Clock;
    logic Reset;
    logic Button;
    logic Level;
    logic Pulse;
    logic ReleasePulse;
    logic LongPulse;

    int unsigned checks;
    int unsigned errors;

    // Reference model: debounced level plus run length of disagreeing samples.
    logic     sq[$];
    logic     m_level;
    int       m_run;
    int       m_hold;
    logic     m_long_done;
    logic     m_pulse;
    logic     m_rel;
    logic     m_longp;

    button_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Button      (Button),
        .Level       (Level),
        .Pulse       (Pulse),
        .ReleasePulse(ReleasePulse),
        .LongPulse   (LongPulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < int'(SYNC); i++) sq.push_back(1'b0);
        m_level     = 1'b0;
        m_run       = 0;
        m_hold      = 0;
        m_long_done = 1'b0;
        m_pulse     = 1'b0;
        m_rel       = 1'b0;
        m_longp     = 1'b0;
    endtask

    // A new level is accepted after DEB+1 consecutive synchronised samples that disagree with it.
    task automatic model_step(input logic b);
        logic s;
        s = sq.pop_front();
        sq.push_back(b);
        m_pulse = 1'b0;
        m_rel   = 1'b0;
        m_longp = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_pulse     = 1'b1;
                    m_hold      = 1;
                    m_long_done = 1'b0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            if (m_level && m_run == 0 && !m_long_done) begin
                if (m_hold == int'(LONG)) begin
                    m_longp     = 1'b1;
                    m_long_done = 1'b1;
                end else begin
                    m_hold++;
                end
            end
            m_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset) model_reset();
        else model_step(Button);
        #1;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Button = 1'b0;
        model_reset();
        tick();
        tick();
        checks++;
        if ({Level, Pulse, ReleasePulse, LongPulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000", {Level, Pulse, ReleasePulse, LongPulse});
        end
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({Level, Pulse, ReleasePulse, LongPulse} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_after_reset: cyc %0d got %b want 0000", c,
                         {Level, Pulse, ReleasePulse, LongPulse});
            end
        end
    endtask

    task automatic test_clean_press();
        Button = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if ({Pulse, Level, LongPulse} !== {c == 7, c >= 7, 1'b0}) begin
                errors++;
                $display("FAIL clean_press: cyc %0d Pulse/Level/Long got %b want %b", c,
                         {Pulse, Level, LongPulse}, {c == 7, c >= 7, 1'b0});
            end
        end
        Button = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if ({ReleasePulse, Level, LongPulse} !== {c == 7, c < 7, 1'b0}) begin
                errors++;
                $display("FAIL clean_release: cyc %0d Rel/Level/Long got %b want %b", c,
                         {ReleasePulse, Level, LongPulse}, {c == 7, c < 7, 1'b0});
            end
        end
    endtask

    task automatic test_bounce();
        int unsigned seg[4] = '{3, 2, 3, 10};
        for (int k = 0; k < 4; k++) begin
            Button = (k % 2 == 0);
            for (int unsigned c = 0; c < seg[k]; c++) begin
                tick();
                checks++;
                if ({Level, Pulse, ReleasePulse, LongPulse} !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce_reject: seg %0d got %b want 0000", k,
                             {Level, Pulse, ReleasePulse, LongPulse});
                end
            end
        end
        Button = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if (Pulse !== (c == 7)) begin
                errors++;
                $display("FAIL bounce_then_hold: cyc %0d Pulse got %b want %b", c, Pulse, c == 7);
            end
        end
        Button = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_long_press();
        int unsigned nlong;
        nlong  = 0;
        Button = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            nlong += LongPulse;
            checks++;
            if ({Pulse, LongPulse} !== {c == 7, c == 17}) begin
                errors++;
                $display("FAIL long_press: cyc %0d Pulse/Long got %b want %b", c,
                         {Pulse, LongPulse}, {c == 7, c == 17});
            end
        end
        checks++;
        if (nlong != 1) begin
            errors++;
            $display("FAIL long_once: got %0d LongPulses want 1", nlong);
        end
        Button = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if ({ReleasePulse, Level} !== {c == 7, c < 7}) begin
                errors++;
                $display("FAIL long_release: cyc %0d Rel/Level got %b want %b", c,
                         {ReleasePulse, Level}, {c == 7, c < 7});
            end
        end
    endtask

    // Two low cycles (sampled at edges 10,11) cost three uncounted FSM cycles.
    task automatic test_release_glitch();
        Button = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 9) Button = 1'b0;
            if (c == 11) Button = 1'b1;
            checks++;
            if ({Pulse, ReleasePulse, LongPulse, Level} !== {c == 7, 1'b0, c == 20, c >= 7}) begin
                errors++;
                $display("FAIL release_glitch: cyc %0d P/R/L/Lvl got %b want %b", c,
                         {Pulse, ReleasePulse, LongPulse, Level}, {c == 7, 1'b0, c == 20, c >= 7});
            end
        end
    endtask

    task automatic test_reset_mid();
        // Still in LONG_HELD from the previous scenario; reset between edges.
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Level, Pulse, ReleasePulse, LongPulse} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b want 0000", {Level, Pulse, ReleasePulse, LongPulse});
        end
        tick();
        Reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if ({Pulse, ReleasePulse, Level} !== {c == 7, 1'b0, c >= 7}) begin
                errors++;
                $display("FAIL reset_refresh: cyc %0d P/R/Lvl got %b want %b", c,
                         {Pulse, ReleasePulse, Level}, {c == 7, 1'b0, c >= 7});
            end
        end
        Button = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_back_to_back();
        int unsigned np, nr;
        logic        prev_p, prev_r;
        np = 0; nr = 0; prev_p = 1'b0; prev_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            Button = (k % 2 == 0);
            for (int c = 0; c < ((k == 1) ? 5 : 12); c++) begin
                tick();
                np += Pulse;
                nr += ReleasePulse;
                checks++;
                if ((Pulse && (ReleasePulse || LongPulse || prev_p)) || (ReleasePulse && prev_r)) begin
                    errors++;
                    $display("FAIL b2b_width: P/R/L got %b prevP %b prevR %b",
                             {Pulse, ReleasePulse, LongPulse}, prev_p, prev_r);
                end
                prev_p = Pulse;
                prev_r = ReleasePulse;
            end
        end
        checks++;
        if (np != 2 || nr != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses %0d releases want 2 and 2", np, nr);
        end
    endtask

    task automatic test_random();
        int unsigned run;
        for (int seg = 0; seg < 60; seg++) begin
            Button = ~Button;
            run = (seg % 3 == 0) ? $urandom_range(8, 20) : $urandom_range(1, 7);
            for (int unsigned c = 0; c < run; c++) begin
                tick();
                checks++;
                if ({Level, Pulse, ReleasePulse, LongPulse} !== {m_level, m_pulse, m_rel, m_longp}) begin
                    errors++;
                    $display("FAIL random_model: seg %0d got %b want %b", seg,
                             {Level, Pulse, ReleasePulse, LongPulse},
                             {m_level, m_pulse, m_rel, m_longp});
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
